fifosc_wr_arb: RTL and testbench

Round-robin write arbiter that shares one fifosc instance between NUM_REQ producers. It also sequences FIFO flushes. Each producer presents a request and its data. The arbiter selects one winner per cycle, drives fifosc insert/di directly, and returns a one-cycle grant to the winner. A flush request runs a FLUSH/HOLD state machine that clears the FIFO and blocks grants until the FIFO has settled.

---
 rtl/fifosc_wr_arb.sv | 113 +++++++++++
 tb/tb_fifosc_wr_arb.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifosc_wr_arb.sv
// Round-robin write arbiter in front of a single fifosc.
// Also sequences FIFO flushes through a FLUSH/HOLD state machine.
module fifosc_wr_arb #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 4,
  parameter int FLUSH_HOLD = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  input  logic                          flush_req,
  output logic                          flush_done,
  output logic                          busy,
  input  logic                          fifo_full,
  output logic                          fifo_insert,
  output logic [DATA_WIDTH-1:0]         fifo_di,
  output logic                          fifo_flush
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    HOLD
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n;
  logic [3:0]    hold_cnt, hold_cnt_n;
  logic          done_n;

  logic          found;
  logic [PW-1:0] win;
  logic          can_grant;

  // Scan from rr_ptr upward, wrapping, for the first active request
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign can_grant = (state == IDLE) && !rst && !flush_req
                   && !fifo_full && found;

  always_comb begin
    gnt         = '0;
    fifo_insert = 1'b0;
    fifo_di     = '0;
    if (can_grant) begin
      gnt         = NUM_REQ'(1) << win;
      fifo_insert = 1'b1;
      fifo_di     = req_data[win*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign fifo_flush = rst || (state == FLUSH);
  assign busy       = (state != IDLE);

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    hold_cnt_n = hold_cnt;
    done_n     = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush_req) begin
          state_n = FLUSH;
        end else if (can_grant) begin
          rr_ptr_n = (win == PW'(NUM_REQ-1)) ? '0 : win + 1'b1;
        end
      end
      FLUSH: begin
        state_n    = HOLD;
        hold_cnt_n = 4'(FLUSH_HOLD-1);
      end
      HOLD: begin
        if (hold_cnt == 4'd0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      hold_cnt   <= 4'd0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      hold_cnt   <= hold_cnt_n;
      flush_done <= done_n;
    end
  end

endmodule

// File: tb/tb_fifosc_wr_arb.sv
// Directed bench for fifosc_wr_arb with a small behavioural FIFO
// (depth 8) standing in for fifosc.
module tb_fifosc_wr_arb;

  localparam int NR    = 2;
  localparam int DW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] gnt;
  logic          flush_req;
  logic          flush_done;
  logic          busy;
  logic          fifo_full;
  logic          fifo_insert;
  logic [DW-1:0] fifo_di;
  logic          fifo_flush;

  logic          force_full;
  logic          rem;
  logic [DW-1:0] q[$];
  int            fcnt = 0;
  logic [DW-1:0] fdo = '0;

  int n_chk  = 0;
  int n_fail = 0;

  fifosc_wr_arb #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .FLUSH_HOLD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .flush_req(flush_req),
    .flush_done(flush_done),
    .busy(busy),
    .fifo_full(fifo_full),
    .fifo_insert(fifo_insert),
    .fifo_di(fifo_di),
    .fifo_flush(fifo_flush)
  );

  always #5 clk = ~clk;

  assign fifo_full = force_full || (fcnt == DEPTH);

  always @(posedge clk) begin
    if (fifo_flush) begin
      q.delete();
    end else begin
      if (rem && q.size() != 0) void'(q.pop_front());
      if (fifo_insert && q.size() < DEPTH) q.push_back(fifo_di);
    end
    fcnt = q.size();
    fdo  = (q.size() != 0) ? q[0] : '0;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] seq_g[4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  logic [DW-1:0] seq_d[4] = '{4'hA, 4'h3, 4'hA, 4'h3};

  initial begin
    rst = 1'b1;
    req = 2'b11;
    req_data = {4'hA, 4'h3};
    flush_req = 1'b0;
    force_full = 1'b0;
    rem = 1'b0;

    // 1: reset
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_ins", 32'(fifo_insert), 0);
      chk("rst_flush", 32'(fifo_flush), 1);
      tick();
    end
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(flush_done), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_gnt", 32'(gnt), 1);
    chk("post_rst_di", 32'(fifo_di), 4'h3);
    chk("post_rst_flush", 32'(fifo_flush), 0);
    tick();

    // 2: fairness
    for (int i = 0; i < 4; i++) begin
      chk("rr_gnt", 32'(gnt), 32'(seq_g[i]));
      chk("rr_di", 32'(fifo_di), 32'(seq_d[i]));
      chk("rr_ins", 32'(fifo_insert), 1);
      tick();
    end

    // 3: backpressure, rr_ptr now 1
    force_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_gnt", 32'(gnt), 0);
      chk("bp_ins", 32'(fifo_insert), 0);
      chk("bp_di", 32'(fifo_di), 0);
      tick();
    end
    force_full = 1'b0;
    #1;
    chk("bp_rel_gnt", 32'(gnt), 2'b10);
    chk("bp_rel_di", 32'(fifo_di), 4'hA);
    tick();

    // 4: flush sequence
    req = 2'b01;
    flush_req = 1'b1;
    #1;
    chk("fl_req_gnt", 32'(gnt), 0);
    chk("fl_req_ins", 32'(fifo_insert), 0);
    tick();
    flush_req = 1'b0;
    #1;
    chk("fl_flush", 32'(fifo_flush), 1);
    chk("fl_busy", 32'(busy), 1);
    chk("fl_gnt", 32'(gnt), 0);
    tick();
    flush_req = 1'b1;
    #1;
    chk("hold1_gnt", 32'(gnt), 0);
    chk("hold1_flush", 32'(fifo_flush), 0);
    chk("hold1_done", 32'(flush_done), 0);
    tick();
    flush_req = 1'b0;
    #1;
    chk("hold2_gnt", 32'(gnt), 0);
    chk("hold2_busy", 32'(busy), 1);
    chk("fifo_cleared", 32'(fcnt), 0);
    tick();
    chk("fl_done", 32'(flush_done), 1);
    chk("fl_done_busy", 32'(busy), 0);
    chk("fl_done_gnt", 32'(gnt), 2'b01);
    tick();
    chk("fl_done_pulse", 32'(flush_done), 0);
    chk("fl_after_gnt", 32'(gnt), 2'b01);
    chk("fl_after_flush", 32'(fifo_flush), 0);
    req = 2'b00;
    tick();

    // empty the FIFO with a second flush
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("e2e_start_empty", 32'(fcnt), 0);

    // 5: producer 1 streams 1,2,3,... until full
    req = 2'b10;
    for (int i = 0; i < 10; i++) begin
      req_data = {4'(i + 1), 4'h0};
      #1;
      chk("e2e_ins", 32'(fifo_insert), (i < DEPTH) ? 1 : 0);
      chk("e2e_full", 32'(fifo_full), (i >= DEPTH) ? 1 : 0);
      tick();
    end
    req = 2'b00;
    rem = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("e2e_drain", 32'(fdo), 32'(i + 1));
      tick();
    end
    rem = 1'b0;
    chk("e2e_empty", 32'(fcnt), 0);

    // 6: reset during the last HOLD cycle
    req = 2'b01;
    req_data = {4'h0, 4'h5};
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 0);
    chk("mid_done", 32'(flush_done), 0);
    chk("mid_gnt", 32'(gnt), 2'b01);
    chk("mid_di", 32'(fifo_di), 4'h5);
    tick();
    chk("mid_done2", 32'(flush_done), 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
